bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 130 +++++++++++++
 tb/tb_bcd_to_bin.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Define BCD_TO_BIN_CHK_EN to reject inputs with non-decimal nibbles (err=1, bin_out=0).
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   w_bcd_shr;
    logic [BIN_W-1:0]   w_acc_shr;
    logic [BCD_W-1:0]   w_bcd_fix;
    logic               w_bad;

    // Per-digit correction: each nibble is adjusted on its own, no borrow between digits.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] o;
        logic [3:0]       nib;
        o = '0;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[4*d +: 4];
            if (nib >= 4'd8)
                nib = nib - 4'd3;
            o[4*d +: 4] = nib;
        end
        return o;
    endfunction

    function automatic logic has_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++)
            if (v[4*d +: 4] > 4'd9)
                bad = 1'b1;
        return bad;
    endfunction

    assign w_bcd_shr = r_bcd >> 1;
    assign w_acc_shr = {r_bcd[0], r_acc[BIN_W-1:1]};
    assign w_bcd_fix = fix_digits(w_bcd_shr);

`ifdef BCD_TO_BIN_CHK_EN
    logic r_err;
    assign w_bad = has_invalid(bcd_in);
    assign err   = r_err;
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_bad ? S_DONE : S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
`ifdef BCD_TO_BIN_CHK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bcd <= bcd_in;
                        r_acc <= '0;
                        r_cnt <= CNT_W'(BIN_W);
`ifdef BCD_TO_BIN_CHK_EN
                        if (w_bad) begin
                            r_bin <= '0;
                            r_err <= 1'b1;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_fix;
                    r_acc <= w_acc_shr;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last step: the shifted accumulator is the final result.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bin <= w_acc_shr;
`ifdef BCD_TO_BIN_CHK_EN
                        r_err <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: directed scenarios plus randomized conversions
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
`ifdef BCD_TO_BIN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int  bin;
        bit  err;
        bit  known;
        int  acc_cyc;
        int  lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    exp_t q[$];
    int   cyc = 0;
    int   mb = 0;
    int   hold_bin = 0;
    bit   hold_err = 1'b0;
    bit   hold_known = 1'b1;
    bit   mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit is_bad(input logic [4*DIGITS-1:0] v);
        for (int d = 0; d < DIGITS; d++)
            if (v[4*d +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int dec_value(input logic [4*DIGITS-1:0] v);
        int s = 0;
        int w = 1;
        for (int d = 0; d < DIGITS; d++) begin
            s += int'(v[4*d +: 4]) * w;
            w *= 10;
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: acceptance decisions and expected results at each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            mb = 0;
            q.delete();
            hold_bin = 0;
            hold_err = 1'b0;
            hold_known = 1'b1;
        end else if (mb > 0) begin
            mb--;
        end else if (start) begin
            e.err     = CHK && is_bad(bcd_in);
            e.known   = !is_bad(bcd_in) || CHK;
            e.bin     = e.err ? 0 : dec_value(bcd_in);
            e.acc_cyc = cyc;
            e.lat     = e.err ? 1 : BIN_W + 1;
            mb        = e.lat;
            q.push_back(e);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_latency", cyc - e.acc_cyc + 1, e.lat);
                    check("err_at_done", int'(err), int'(e.err));
                    if (e.known) check("bin_at_done", int'(bin_out), e.bin);
                    hold_bin   = e.bin;
                    hold_err   = e.err;
                    hold_known = e.known;
                end
            end else if (q.size() > 0 && (cyc - q[0].acc_cyc + 1) >= q[0].lat) begin
                check("missing_done", 0, 1);
                void'(q.pop_front());
            end
            check("busy", int'(busy), int'(mb > 0));
            if (hold_known) check("bin_hold", int'(bin_out), hold_bin);
            check("err_hold", int'(err), int'(hold_err));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (mb != 0 && k < 50) begin
            tick();
            k++;
        end
        if (mb != 0) check("idle_timeout", mb, 0);
    endtask

    task automatic issue(input logic [4*DIGITS-1:0] v);
        wait_idle();
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    function automatic logic [4*DIGITS-1:0] rand_bcd();
        logic [4*DIGITS-1:0] v;
        for (int d = 0; d < DIGITS; d++)
            v[4*d +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0)
            v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin", int'(bin_out), 0);
        check("rst_err", int'(err), 0);
        mon_en = 1'b1;

        issue(12'h999);
        issue(12'h000);
        issue(12'h123);
        issue(12'h5A3);
        issue(12'h047);

        issue(12'h456);
        tick(3);
        bcd_in = 12'h789;
        start  = 1'b1;
        tick();
        start  = 1'b0;

        issue(12'h321);
        tick(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(12'h042);

        wait_idle();
        bcd_in = 12'h250;
        start  = 1'b1;
        tick(40);
        start  = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int r;
            tick($urandom_range(0, 3));
            issue(rand_bcd());
            r = $urandom_range(0, 19);
            if (r < 3) begin
                tick($urandom_range(0, 8));
                bcd_in = rand_bcd();
                start  = 1'b1;
                tick();
                start  = 1'b0;
            end else if (r == 3) begin
                tick($urandom_range(0, 10));
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        wait_idle();
        tick(3);
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
